// File: rtl/pipe_pkg.sv
// Shared types and per-boundary widths for the pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } stage_state_e;

  localparam int unsigned DefCntW = 16;

  // Bundle widths at each inter-stage boundary.
  localparam int unsigned IfIdCtrlW  = 1;
  localparam int unsigned IfIdDataW  = 64;
  localparam int unsigned IdExCtrlW  = 10;
  localparam int unsigned IdExDataW  = 122;
  localparam int unsigned ExMemCtrlW = 4;
  localparam int unsigned ExMemDataW = 69;
  localparam int unsigned MemWbCtrlW = 2;
  localparam int unsigned MemWbDataW = 69;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// synchronous flush to a zeroed bubble and saturating stall/bubble counters.
module pipe_stage_latch
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = IdExCtrlW,
  parameter int unsigned DATA_W = IdExDataW,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              inicio,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned PayW = CTRL_W + DATA_W;

  stage_state_e state_q, state_d;
  logic [PayW-1:0] main_q, main_d;
  logic [PayW-1:0] skid_q, skid_d;
  logic [PayW-1:0] in_pay;
  logic            in_ready_q;
  logic            accept;
  logic            transfer;

  assign in_pay    = {in_ctrl, in_data};
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;

  // With SKID=0 the FULL state is unreachable: accept in ONE implies transfer.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          main_d  = in_pay;
        end
      end
      StOne: begin
        if (accept && transfer) begin
          main_d = in_pay;
        end else if (accept) begin
          state_d = StFull;
          skid_d  = in_pay;
        end else if (transfer) begin
          state_d = StEmpty;
          main_d  = '0;
        end
      end
      StFull: begin
        if (transfer) begin
          state_d = StOne;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = StEmpty;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
    // Flush wins over the handshake and drops any same-cycle input.
    if (flush) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (inicio) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  assign out_ctrl = main_q[PayW-1:DATA_W];
  assign out_data = main_q[DATA_W-1:0];

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (inicio),
    .inc  (out_valid && !out_ready),
    .count(stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .clr  (inicio),
    .inc  (!out_valid),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: a SKID=1 and a SKID=0 instance share stimulus and are
// compared every cycle against a queue-based model, plus directed corner cases.
module tb_pipe_stage_latch;

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 122;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          inicio, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          ov [2];
  logic          ir [2];
  logic [CW-1:0] oc [2];
  logic [DW-1:0] od [2];
  logic [15:0]   sc1, bc1;
  logic [3:0]    sc0, bc0;

  pipe_stage_latch #(
    .CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)
  ) dut1 (
    .clk(clk), .inicio(inicio), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]), .out_data(od[1]),
    .stall_cnt(sc1), .bubble_cnt(bc1)
  );

  pipe_stage_latch #(
    .CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(4)
  ) dut0 (
    .clk(clk), .inicio(inicio), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]), .out_data(od[0]),
    .stall_cnt(sc0), .bubble_cnt(bc0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a FIFO of up to 2 (SKID=1) or 1 (SKID=0) entries per instance.
  int unsigned   m_n [2];
  logic [CW-1:0] m_c [2][2];
  logic [DW-1:0] m_d [2][2];
  int unsigned   m_stall [2];
  int unsigned   m_bub [2];
  bit            model_ok = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_ready(int k);
    if (k == 1) return m_n[1] < 2;
    return (m_n[0] == 0) || out_ready;
  endfunction

  task automatic check_dut(input int k);
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic [15:0]   s, b;
    ec = (m_n[k] > 0) ? m_c[k][0] : '0;
    ed = (m_n[k] > 0) ? m_d[k][0] : '0;
    s  = (k == 1) ? sc1 : {12'b0, sc0};
    b  = (k == 1) ? bc1 : {12'b0, bc0};
    chk($sformatf("out_valid[%0d]", k), 128'(ov[k]), 128'(m_n[k] > 0));
    chk($sformatf("out_ctrl[%0d]", k), 128'(oc[k]), 128'(ec));
    chk($sformatf("out_data[%0d]", k), 128'(od[k]), 128'(ed));
    chk($sformatf("in_ready[%0d]", k), 128'(ir[k]), 128'(m_ready(k)));
    chk($sformatf("stall_cnt[%0d]", k), 128'(s), 128'(m_stall[k]));
    chk($sformatf("bubble_cnt[%0d]", k), 128'(b), 128'(m_bub[k]));
  endtask

  task automatic model_edge(input int k);
    int unsigned cap;
    bit rdy, v;
    cap = (k == 1) ? 65535 : 15;
    rdy = m_ready(k);
    v   = m_n[k] > 0;
    if (inicio) begin
      m_n[k] = 0;
      m_stall[k] = 0;
      m_bub[k] = 0;
    end else begin
      if (v && !out_ready && m_stall[k] < cap) m_stall[k]++;
      if (!v && m_bub[k] < cap) m_bub[k]++;
      if (flush) begin
        m_n[k] = 0;
      end else begin
        if (v && out_ready) begin
          m_c[k][0] = m_c[k][1];
          m_d[k][0] = m_d[k][1];
          m_n[k]--;
        end
        if (in_valid && rdy) begin
          m_c[k][m_n[k]] = in_ctrl;
          m_d[k][m_n[k]] = in_data;
          m_n[k]++;
        end
      end
    end
  endtask

  task automatic drive(input logic ini, input logic fl, input logic iv, input logic ordy,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    @(negedge clk);
    inicio = ini; flush = fl; in_valid = iv; out_ready = ordy;
    in_ctrl = c; in_data = d;
    #1;
    if (model_ok) begin
      check_dut(0);
      check_dut(1);
    end
  endtask

  task automatic advance();
    model_edge(0);
    model_edge(1);
    if (inicio) model_ok = 1'b1;
    @(posedge clk);
  endtask

  task automatic step(input logic ini, input logic fl, input logic iv, input logic ordy,
                      input logic [CW-1:0] c, input logic [DW-1:0] d);
    drive(ini, fl, iv, ordy, c, d);
    advance();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, '1, '1);
    step(1'b1, 1'b0, 1'b1, 1'b0, '1, '1);
  endtask

  typedef struct {
    logic       iv;
    logic       ordy;
    logic [7:0] din;
    logic       exp_v;
    logic       exp_r;
    logic [7:0] exp_d;
    int         exp_stall;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [15:0]  s_hold, b_hold;
    logic [127:0] r;

    inicio = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    // Backpressure sequence on the SKID=1 instance: A, B, C with 3 stall cycles.
    tbl[0] = '{1'b1, 1'b1, 8'h0A, 1'b0, 1'b1, 8'h00, 0};
    tbl[1] = '{1'b1, 1'b0, 8'h0B, 1'b1, 1'b1, 8'h0A, 0};
    tbl[2] = '{1'b1, 1'b0, 8'h0C, 1'b1, 1'b0, 8'h0A, 1};
    tbl[3] = '{1'b1, 1'b0, 8'h0C, 1'b1, 1'b0, 8'h0A, 2};
    tbl[4] = '{1'b1, 1'b1, 8'h0C, 1'b1, 1'b0, 8'h0A, 3};
    tbl[5] = '{1'b1, 1'b1, 8'h0C, 1'b1, 1'b1, 8'h0B, 3};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h0C, 3};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 3};

    // Reset with in_valid held high.
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid[%0d]", k), 128'(ov[k]), 128'(0));
      chk($sformatf("rst_ctrl[%0d]", k), 128'(oc[k]), 128'(0));
      chk($sformatf("rst_ready[%0d]", k), 128'(ir[k]), 128'(1));
    end
    chk("rst_stall", 128'(sc1), 128'(0));
    chk("rst_bubble", 128'(bc1), 128'(0));
    advance();

    // Table-driven backpressure.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, tbl[i].iv, tbl[i].ordy, CW'(tbl[i].din), DW'(tbl[i].din));
      chk($sformatf("bp_valid%0d", i), 128'(ov[1]), 128'(tbl[i].exp_v));
      chk($sformatf("bp_ready%0d", i), 128'(ir[1]), 128'(tbl[i].exp_r));
      chk($sformatf("bp_data%0d", i), 128'(od[1]), 128'(tbl[i].exp_d));
      chk($sformatf("bp_stall%0d", i), 128'(sc1), 128'(tbl[i].exp_stall));
      advance();
    end

    // Streaming 8 items back to back.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b0, i <= 8, 1'b1, CW'(i), DW'(i));
      if (i >= 2) begin
        chk($sformatf("stream_data%0d", i - 1), 128'(od[1]), 128'(i - 1));
        chk($sformatf("stream_valid%0d", i - 1), 128'(ov[1]), 128'(1));
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("stream_stall", 128'(sc1), 128'(0));
    advance();

    // Flush while FULL with an all-ones input that must be dropped.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, CW'(3), DW'(3));
    step(1'b0, 1'b0, 1'b1, 1'b0, CW'(4), DW'(4));
    drive(1'b0, 1'b1, 1'b1, 1'b1, '1, '1);
    s_hold = sc1;
    b_hold = bc1;
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("flush_valid", 128'(ov[1]), 128'(0));
    chk("flush_ctrl", 128'(oc[1]), 128'(0));
    chk("flush_data", 128'(od[1]), 128'(0));
    chk("flush_ready", 128'(ir[1]), 128'(1));
    chk("flush_stall", 128'(sc1), 128'(s_hold));
    chk("flush_bubble", 128'(bc1), 128'(b_hold));
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("flush_dropped", 128'(ov[1]), 128'(0));
    advance();

    // 4-bit bubble counter saturates.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("sat_bubble", 128'(bc0), 128'(15));
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("sat_bubble_hold", 128'(bc0), 128'(15));
    advance();

    // SKID=0: combinational in_ready.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, CW'(5), DW'(5));
    drive(1'b0, 1'b0, 1'b1, 1'b0, CW'(6), DW'(6));
    chk("s0_ready_low", 128'(ir[0]), 128'(0));
    chk("s0_valid", 128'(ov[0]), 128'(1));
    out_ready = 1'b1;
    #1;
    chk("s0_ready_comb", 128'(ir[0]), 128'(1));
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("s0_loaded", 128'(od[0]), 128'(6));
    advance();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           r[CW-1:0], r[DW-1:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_latch.md
# pipe_stage_latch

Parametrised pipeline stage register for the MIPS pipeline, the successor to the fixed ID/EX latch. It carries a control bundle plus a data bundle between two stages with a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush that inserts a zeroed bubble, and saturating stall/bubble counters. It is instantiated at each inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-boundary widths.

## Interface
- CTRL_W, 10: control bundle width (RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, RegDst, ...).
- DATA_W, 122: data bundle width (RD1, RD2, Rs, Rt, Rd, SignImm, ...).
- SKID, 1: 1 = 2-entry skid buffer, fully registered in_ready; 0 = single register, combinational in_ready.
- CNT_W, 16: width of each performance counter.
- clk  in  1  clock, rising edge.
- inicio  in  1  reset: synchronous, active-high; clears everything including counters.
- flush  in  1  synchronous stage flush (FlushE-style); clears contents, not counters.
- in_valid  in  1  upstream stage has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  output holds a live instruction.
- out_ready  in  1  downstream consumes this cycle.
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0.
- out_data  out  DATA_W  registered data; all-zero whenever out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0.

## Operation
- Accept = in_valid && in_ready; transfer = out_valid && out_ready.
- SKID=1 states: EMPTY, ONE (main valid), FULL (main + skid valid). in_ready = (state != FULL), registered.
  - EMPTY: accept → ONE, main ← input.
  - ONE: accept && transfer → ONE, main ← input; accept && !transfer → FULL, skid ← input; !accept && transfer → EMPTY; else hold.
  - FULL: transfer → ONE, main ← skid, skid cleared to zero; else hold.
- SKID=0: single register; in_ready = !out_valid || out_ready (combinational). Accept loads; transfer without accept → empty.
- Whenever a register becomes empty, its ctrl and data fields are written to zero, so a bubble never asserts RegWrite/MemWrite.
- Priority: inicio > flush > handshake. Flush → EMPTY, both entries zeroed, the same-cycle input is discarded even if in_ready=1.
- Counters: saturate at 2^CNT_W−1, never wrap; cleared only by inicio; they count on the cycle the condition holds, flush cycles included.

## Timing
- After inicio: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, in_ready=1, both counters 0.
- Latency is 1 cycle. Input accepted at edge N appears on out_* after edge N, with no combinational in→out path.
- SKID=1 sustains 1 transfer/cycle. A downstream stall costs no upstream bubble until the skid fills. in_ready drops the cycle after entering FULL.
- Order is preserved: the skid entry is always younger than main.
- Flush asserted at edge N: out_valid=0 after edge N. Input is accepted again from edge N+1.
- Simultaneous accept and transfer in EMPTY cannot occur (out_valid=0).

## Structure
- Shared package `pipe_pkg`: state enum {EMPTY, ONE, FULL}, default CNT_W, and per-boundary CTRL_W/DATA_W constants.
- Sub-module `sat_counter` (CNT_W, inc, clr) is instantiated twice.
- The payload register pair and the state machine stay in one module.

## Test plan
- Reset: drive inicio=1 for 2 cycles with in_valid=1 → out_valid=0, out_ctrl=0, in_ready=1, counters 0.
- Streaming, SKID=1: 8 back-to-back items 0x1..0x8 with out_ready=1 → out_data 0x1..0x8 on consecutive cycles, 1-cycle latency, stall_cnt=0.
- Backpressure: out_ready=0 for 3 cycles while streaming A, B, C → skid fills, in_ready=0 after 2 accepts, output A held stable, stall_cnt=3. Release → A, B, C in order, no loss or duplication.
- Flush in FULL with in_valid=1, in_ctrl=all-ones → next cycle out_valid=0, out_ctrl=0, the input is dropped, counters unchanged.
- Saturation: CNT_W=4, idle for 20 cycles → bubble_cnt=15 and holds.
- SKID=0: out_ready=0 with valid output → in_ready=0 in the same cycle. out_ready=1 → in_ready=1 combinationally and the new item loads.
